dma_cmd_initiator: RTL

Host-side initiator for the per-core DMA command interface: turns one transfer request into a burst of 128-bit write commands (packet memory or header region) or read commands plus response collection toward a core's `dma_cmd_*` / `dma_rd_resp_*` ports. It sits in the scheduler/interconnect domain, one instance per core slot, directly in front of the core's pipeline-register wrapper. It serves one request at a time and reports completion on a done channel.

---
 rtl/dma_cmd_pkg.sv | 25 ++
 rtl/dma_cmd_initiator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_cmd_pkg.sv
// Shared types and helpers for the per-core DMA command initiator:
// FSM state encoding, beat size and the partial last-beat strobe function.
package dma_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int BEAT_BYTES = 16;

   // Strobe for the final beat: low len[3:0] bytes valid, zero means a full beat.
   function automatic logic [BEAT_BYTES-1:0] last_strb(input logic [3:0] len_lo);
      logic [BEAT_BYTES-1:0] strb_v;
      if (len_lo == 4'd0) begin
         strb_v = {BEAT_BYTES{1'b1}};
      end else begin
         strb_v = ({{(BEAT_BYTES-1){1'b0}}, 1'b1} << len_lo) - {{(BEAT_BYTES-1){1'b0}}, 1'b1};
      end
      return strb_v;
   endfunction

endpackage

// File: rtl/dma_cmd_initiator.sv
// Host-side DMA initiator: converts one request into a burst of 128-bit write
// commands or read commands plus in-order response collection, then reports done.
module dma_cmd_initiator
   import dma_cmd_pkg::*;
#(
   parameter int DATA_WIDTH     = 128,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH     = 26,
   parameter int HDR_ADDR_WIDTH = 24,
   parameter int LEN_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_wr,
   input  logic                      req_hdr,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [LEN_WIDTH-1:0]      req_len,
   input  logic [DATA_WIDTH-1:0]     s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic                      dma_cmd_wr_en,
   output logic [ADDR_WIDTH-1:0]     dma_cmd_wr_addr,
   output logic                      dma_cmd_hdr_wr_en,
   output logic [HDR_ADDR_WIDTH-1:0] dma_cmd_hdr_wr_addr,
   output logic [DATA_WIDTH-1:0]     dma_cmd_wr_data,
   output logic [STRB_WIDTH-1:0]     dma_cmd_wr_strb,
   output logic                      dma_cmd_wr_last,
   input  logic                      dma_cmd_wr_ready,
   output logic                      dma_cmd_rd_en,
   output logic [ADDR_WIDTH-1:0]     dma_cmd_rd_addr,
   output logic                      dma_cmd_rd_last,
   input  logic                      dma_cmd_rd_ready,
   input  logic                      dma_rd_resp_valid,
   input  logic [DATA_WIDTH-1:0]     dma_rd_resp_data,
   output logic                      dma_rd_resp_ready,
   output logic [DATA_WIDTH-1:0]     m_data,
   output logic [STRB_WIDTH-1:0]     m_strb,
   output logic                      m_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      done_valid,
   output logic                      done_err,
   input  logic                      done_ready
);

   localparam int CNT_W = LEN_WIDTH - 4 + 1;

   state_e                  state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [LEN_WIDTH-1:0]    len_r;
   logic                    hdr_r, err_r;
   logic [CNT_W-1:0]        beats_r, cmd_cnt_r, rsp_cnt_r;
   logic [LEN_WIDTH:0]      len_round_s;
   logic [CNT_W-1:0]        beats_s;
   logic                    req_bad_s, cmd_last_s, rsp_last_s, cmd_pending_s;
   logic                    wr_fire_s, rd_fire_s, rsp_fire_s;
   logic [STRB_WIDTH-1:0]   tail_strb_s;

   assign len_round_s   = {1'b0, req_len} + {{(LEN_WIDTH-3){1'b0}}, 4'hF};
   assign beats_s       = len_round_s[LEN_WIDTH:4];
   assign req_bad_s     = (req_len == {LEN_WIDTH{1'b0}}) || (req_addr[3:0] != 4'd0);
   assign cmd_last_s    = (cmd_cnt_r == beats_r - CNT_W'(1));
   assign rsp_last_s    = (rsp_cnt_r == beats_r - CNT_W'(1));
   assign cmd_pending_s = (cmd_cnt_r < beats_r);
   assign tail_strb_s   = last_strb(len_r[3:0]);

   // State, request context and beat counters; reset clears everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         addr_r    <= {ADDR_WIDTH{1'b0}};
         len_r     <= {LEN_WIDTH{1'b0}};
         hdr_r     <= 1'b0;
         err_r     <= 1'b0;
         beats_r   <= {CNT_W{1'b0}};
         cmd_cnt_r <= {CNT_W{1'b0}};
         rsp_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_r    <= req_addr;
                  len_r     <= req_len;
                  hdr_r     <= req_wr & req_hdr;
                  err_r     <= req_bad_s;
                  beats_r   <= beats_s;
                  cmd_cnt_r <= {CNT_W{1'b0}};
                  rsp_cnt_r <= {CNT_W{1'b0}};
               end
            end
            ST_WR: begin
               if (wr_fire_s) begin
                  addr_r    <= addr_r + ADDR_WIDTH'(BEAT_BYTES);
                  cmd_cnt_r <= cmd_cnt_r + CNT_W'(1);
               end
            end
            ST_RD: begin
               if (rd_fire_s) begin
                  addr_r    <= addr_r + ADDR_WIDTH'(BEAT_BYTES);
                  cmd_cnt_r <= cmd_cnt_r + CNT_W'(1);
               end
               if (rsp_fire_s) begin
                  rsp_cnt_r <= rsp_cnt_r + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next state and all handshake/datapath outputs; everything is held low during reset.
   always_comb begin
      state_nxt_s         = state_r;
      req_ready           = 1'b0;
      s_ready             = 1'b0;
      dma_cmd_wr_en       = 1'b0;
      dma_cmd_hdr_wr_en   = 1'b0;
      dma_cmd_wr_addr     = {ADDR_WIDTH{1'b0}};
      dma_cmd_hdr_wr_addr = {HDR_ADDR_WIDTH{1'b0}};
      dma_cmd_wr_data     = {DATA_WIDTH{1'b0}};
      dma_cmd_wr_strb     = {STRB_WIDTH{1'b0}};
      dma_cmd_wr_last     = 1'b0;
      dma_cmd_rd_en       = 1'b0;
      dma_cmd_rd_addr     = {ADDR_WIDTH{1'b0}};
      dma_cmd_rd_last     = 1'b0;
      dma_rd_resp_ready   = 1'b0;
      m_data              = {DATA_WIDTH{1'b0}};
      m_strb              = {STRB_WIDTH{1'b0}};
      m_last              = 1'b0;
      m_valid             = 1'b0;
      done_valid          = 1'b0;
      done_err            = 1'b0;
      wr_fire_s           = 1'b0;
      rd_fire_s           = 1'b0;
      rsp_fire_s          = 1'b0;
      if (!rst) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               req_ready = 1'b1;
               if (!req_valid) begin
                  state_nxt_s = ST_IDLE;
               end else if (req_bad_s) begin
                  state_nxt_s = ST_DONE;
               end else if (req_wr) begin
                  state_nxt_s = ST_WR;
               end else begin
                  state_nxt_s = ST_RD;
               end
            end
            ST_WR: begin
               s_ready             = dma_cmd_wr_ready;
               dma_cmd_wr_en       = s_valid;
               dma_cmd_hdr_wr_en   = s_valid & hdr_r;
               dma_cmd_wr_addr     = addr_r;
               dma_cmd_hdr_wr_addr = addr_r[HDR_ADDR_WIDTH-1:0];
               dma_cmd_wr_data     = s_data;
               dma_cmd_wr_strb     = cmd_last_s ? tail_strb_s : {STRB_WIDTH{1'b1}};
               dma_cmd_wr_last     = cmd_last_s;
               wr_fire_s           = s_valid & dma_cmd_wr_ready;
               if (wr_fire_s && cmd_last_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_WR;
               end
            end
            ST_RD: begin
               // Command issue and response collection progress independently.
               dma_cmd_rd_en     = cmd_pending_s;
               dma_cmd_rd_addr   = addr_r;
               dma_cmd_rd_last   = cmd_pending_s & cmd_last_s;
               rd_fire_s         = cmd_pending_s & dma_cmd_rd_ready;
               dma_rd_resp_ready = m_ready;
               m_valid           = dma_rd_resp_valid;
               m_data            = dma_rd_resp_data;
               m_strb            = rsp_last_s ? tail_strb_s : {STRB_WIDTH{1'b1}};
               m_last            = rsp_last_s;
               rsp_fire_s        = dma_rd_resp_valid & m_ready;
               if (rsp_fire_s && rsp_last_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_RD;
               end
            end
            ST_DONE: begin
               done_valid = 1'b1;
               done_err   = err_r;
               if (done_ready) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

endmodule
